// File: rtl/gate_counter.sv
// gate_counter: reference/signal dual counter for the SF_Counter chain.
// Synchronizes the asynchronous gate and measured signal into clk. Over each
// gate-high window it counts clk cycles and signal rising edges. At window close
// it latches both counts and offers them through a valid/ready handshake.
// f_sig = f_clk * sig_count / ref_count.
//
// state | meaning
// IDLE  | after reset; wait for the synced gate to be low (no partial window)
// ARMED | waiting for a gate rise to open a window
// COUNT | window open; counting clk cycles and signal rises
// HOLD  | result latched and offered on result_valid
module gate_counter #(
    parameter int CNT_W       = 32,
    parameter int SYNC_STAGES = 2    // 2 or 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sample_gate,
    input  logic             sampled_signal,
    input  logic             result_ready,
    output logic             result_valid,
    output logic [CNT_W-1:0] ref_count,
    output logic [CNT_W-1:0] sig_count,
    output logic             overflow,
    output logic             overrun,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_COUNT = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    // Cycles needed after reset before the synchronizer output reflects the
    // real gate level rather than its reset value.
    localparam logic [1:0]       SETTLE_N = 2'(SYNC_STAGES);

    // ---------------------------------------------------------------------
    // Synchronizers and edge detection
    // ---------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] gate_sync_q, gate_sync_d;
    logic [SYNC_STAGES-1:0] sig_sync_q, sig_sync_d;
    logic                   gate_prev_q, gate_prev_d;
    logic                   sig_prev_q, sig_prev_d;
    logic                   g_lvl, s_lvl;
    logic                   g_rise, g_fall, s_rise;

    assign g_lvl  = gate_sync_q[SYNC_STAGES-1];
    assign s_lvl  = sig_sync_q[SYNC_STAGES-1];
    assign g_rise = g_lvl & ~gate_prev_q;
    assign g_fall = ~g_lvl & gate_prev_q;
    assign s_rise = s_lvl & ~sig_prev_q;

    // Next values of the synchronizer shift chains and edge-detect flops.
    always_comb begin
        gate_sync_d = {gate_sync_q[SYNC_STAGES-2:0], sample_gate};
        sig_sync_d  = {sig_sync_q[SYNC_STAGES-2:0], sampled_signal};
        gate_prev_d = g_lvl;
        sig_prev_d  = s_lvl;
    end

    // Synchronizer and edge-detect registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gate_sync_q <= '0;
            sig_sync_q  <= '0;
            gate_prev_q <= 1'b0;
            sig_prev_q  <= 1'b0;
        end else begin
            gate_sync_q <= gate_sync_d;
            sig_sync_q  <= sig_sync_d;
            gate_prev_q <= gate_prev_d;
            sig_prev_q  <= sig_prev_d;
        end
    end

    // ---------------------------------------------------------------------
    // Control FSM, counters and result registers
    // ---------------------------------------------------------------------
    state_t           state_q, state_d;
    logic [1:0]       settle_q, settle_d;
    logic [CNT_W-1:0] ref_cnt_q, ref_cnt_d;
    logic [CNT_W-1:0] sig_cnt_q, sig_cnt_d;
    logic             ovf_q, ovf_d;
    logic             pend_q, pend_d;
    logic [CNT_W-1:0] ref_count_q, ref_count_d;
    logic [CNT_W-1:0] sig_count_q, sig_count_d;
    logic             overflow_q, overflow_d;
    logic             overrun_q, overrun_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;

    logic [CNT_W-1:0] ref_next, sig_next;
    logic             ovf_next;

    // Saturating increments; checked before adding so the counters never wrap.
    always_comb begin
        ref_next = (ref_cnt_q == CNT_MAX) ? ref_cnt_q : ref_cnt_q + CNT_ONE;
        sig_next = sig_cnt_q;
        if (s_rise && (sig_cnt_q != CNT_MAX)) begin
            sig_next = sig_cnt_q + CNT_ONE;
        end
        ovf_next = ovf_q | (ref_next == CNT_MAX) | (s_rise && (sig_next == CNT_MAX));
    end

    // Next-state and next-output logic for the measurement FSM.
    always_comb begin
        state_d     = state_q;
        settle_d    = settle_q;
        ref_cnt_d   = ref_cnt_q;
        sig_cnt_d   = sig_cnt_q;
        ovf_d       = ovf_q;
        pend_d      = pend_q;
        ref_count_d = ref_count_q;
        sig_count_d = sig_count_q;
        overflow_d  = overflow_q;
        overrun_d   = overrun_q;
        valid_d     = valid_q;
        busy_d      = busy_q;

        case (state_q)
            S_IDLE: begin
                if (settle_q != SETTLE_N) begin
                    settle_d = settle_q + 2'd1;
                end else if (!g_lvl) begin
                    state_d = S_ARMED;
                end
            end
            S_ARMED: begin
                // The signal edge coincident with the opening gate edge is
                // not counted: counting starts on the next cycle.
                if (g_rise) begin
                    ref_cnt_d = '0;
                    sig_cnt_d = '0;
                    ovf_d     = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = S_COUNT;
                end
            end
            S_COUNT: begin
                ref_cnt_d = ref_next;
                sig_cnt_d = sig_next;
                ovf_d     = ovf_next;
                if (g_fall) begin
                    ref_count_d = ref_next;
                    sig_count_d = sig_next;
                    overflow_d  = ovf_next;
                    overrun_d   = pend_q;
                    pend_d      = 1'b0;
                    valid_d     = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = S_HOLD;
                end
            end
            S_HOLD: begin
                if (g_rise) begin
                    pend_d = 1'b1;
                end
                if (valid_q && result_ready) begin
                    valid_d = 1'b0;
                    state_d = S_ARMED;
                end
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // FSM state, counters and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            settle_q    <= 2'd0;
            ref_cnt_q   <= '0;
            sig_cnt_q   <= '0;
            ovf_q       <= 1'b0;
            pend_q      <= 1'b0;
            ref_count_q <= '0;
            sig_count_q <= '0;
            overflow_q  <= 1'b0;
            overrun_q   <= 1'b0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            settle_q    <= settle_d;
            ref_cnt_q   <= ref_cnt_d;
            sig_cnt_q   <= sig_cnt_d;
            ovf_q       <= ovf_d;
            pend_q      <= pend_d;
            ref_count_q <= ref_count_d;
            sig_count_q <= sig_count_d;
            overflow_q  <= overflow_d;
            overrun_q   <= overrun_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
        end
    end

    assign result_valid = valid_q;
    assign ref_count    = ref_count_q;
    assign sig_count    = sig_count_q;
    assign overflow     = overflow_q;
    assign overrun      = overrun_q;
    assign busy         = busy_q;

endmodule

// File: doc/gate_counter.md
# gate_counter

Reference/signal dual counter that consumes the `sample_gate` produced by the gate generator in the SF_Counter measurement chain. It synchronizes the asynchronous gate and measured signal into the system clock domain. Over each gate-high window it counts system clock cycles and measured-signal rising edges. At window close it latches both counts for the readout stage through a valid/ready handshake, so that f_sig = f_clk × sig_count / ref_count.

## Interface
- `CNT_W`, default 32: width of both counters and result outputs.
- `SYNC_STAGES`, default 2: synchronizer flops on each async input; legal values are 2 or 3.

Ports:
- `clk` — input, 1 — system/reference clock; all logic is on its rising edge.
- `reset` — input, 1 — asynchronous, active-high reset.
- `sample_gate` — input, 1 — asynchronous measurement window from the gate generator; high = counting window.
- `sampled_signal` — input, 1 — asynchronous measured signal.
- `result_ready` — input, 1 — consumer accepts the result when high together with `result_valid`.
- `result_valid` — output, 1 — a latched result is available.
- `ref_count` — output, CNT_W — clk cycles in the last window.
- `sig_count` — output, CNT_W — signal rising edges in the last window.
- `overflow` — output, 1 — either counter saturated during the last window.
- `overrun` — output, 1 — a gate-rise was missed while the previous result was pending.
- `busy` — output, 1 — a window is currently being counted.

## Operation
- **Input synchronization**
  - Each async input passes through `SYNC_STAGES` flops, then one edge-detect flop.
  - `g_rise`, `g_fall` and `s_rise` are single-cycle pulses.
  - All synchronizer flops reset to 0.
- **FSM states:** IDLE, ARMED, COUNT, HOLD.
- **IDLE** (reset state)
  - Moves to ARMED on the first cycle the synced gate is low.
  - This prevents a partial window when reset releases mid-gate.
- **ARMED**
  - On `g_rise`: clear `ref_cnt` and `sig_cnt` to 0 and go to COUNT.
  - The `s_rise` coinciding with `g_rise` is not counted. It is the opening edge.
- **COUNT**
  - Every cycle: `ref_cnt` += 1.
  - On `s_rise`: `sig_cnt` += 1.
  - Both counters saturate at 2^CNT_W−1; reaching saturation sets internal `ovf`.
  - On `g_fall`:
    - This cycle's increments still apply, including a coincident `s_rise` (the closing edge is counted).
    - The post-increment values load into `ref_count` and `sig_count`.
    - `ovf` loads into `overflow`.
    - The pending-overrun flag loads into `overrun`, then clears.
    - State goes to HOLD.
- **HOLD**
  - `result_valid` = 1.
  - On `result_valid && result_ready`, go to ARMED.
  - A `g_rise` seen while in HOLD sets the pending-overrun flag; that window is skipped.
- **Output stability:** outputs hold their values from latch until the next latch. They are stable for the whole time `result_valid` is high.
- **`busy`** = (state == COUNT).

## Timing
- **Reset values:** `result_valid`, `busy`, `overflow` and `overrun` are 0; `ref_count` and `sig_count` are 0. Internal `ovf` and the pending-overrun flag are also 0.
- **Detection latency:** each async edge is detected `SYNC_STAGES`+1 clk edges after it arrives. Gate and signal have equal latency, so `ref_count` equals the gate-high width in clk cycles (±1 from sampling).
- **Result latency:** `result_valid` rises on the clk edge after the `g_fall` detection cycle.
- **Handshake:** the transfer occurs on the clk edge where valid and ready are both high. `result_valid` drops on that edge.
- **Back-to-back windows:** ARMED is entered the cycle after the transfer. A `g_rise` on that cycle or later opens a new window.
- **Reset mid-operation:** state returns to IDLE immediately and any pending result is discarded.
- **Arithmetic:** unsigned; saturation is checked before the increment, so no wrap-around.

## Test plan
- **Basic window:** gate high for exactly 1000 clk cycles, `sampled_signal` = clk/10 with gate edges aligned to signal edges (N=100). Required: `ref_count`=1000, `sig_count`=100, `overflow`=0, `overrun`=0, `result_valid` high with `result_ready`=1.
- **Partial window at reset release:** release `reset` while gate is high, then a full 500-cycle window follows. Required: the first result reports 500 cycles; no result for the partial window.
- **Backpressure:** hold `result_ready`=0 across the next full window. Required:
  - the outputs keep the first result;
  - after ready, the next result has `overrun`=1;
  - the result after that has `overrun`=0.
- **Saturation:** `CNT_W`=8 with a 300-cycle window. Required: `ref_count`=255, `overflow`=1.
- **Coincident edges:** signal edges coincide with gate rise and fall, 5 edges strictly inside the window. Required: `sig_count`=6 (opening edge excluded, closing edge included).
- **Reset mid-count and mid-HOLD:** assert `reset` during COUNT and during HOLD. Required: all outputs return to 0 asynchronously, and no stale result appears afterwards.
